// File: rtl/wide_addsub_pkg.sv
// Shared types and default sizing for the multi-cycle wide add/subtract sequencer.
// The index width is forced to at least one bit so a single-slice build still elaborates.
package wide_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int W_DEF     = 128;
  localparam int SLICE_DEF = 32;
  localparam int NSLICE    = W_DEF / SLICE_DEF;

  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

  localparam int IDX_W = idx_width(NSLICE);

endpackage

// File: rtl/add_slice.sv
// Combinational SLICE-bit ripple adder. It also reports the carry into the top bit,
// which the sequencer needs for the signed-overflow flag.
module add_slice #(
  parameter int SLICE = 32
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [SLICE-1:0] low;
  logic [1:0]       top;

  // The low bits are summed one bit wide so their carry-out is the carry into the MSB.
  always_comb begin
    low      = {1'b0, a[SLICE-2:0]} + {1'b0, b[SLICE-2:0]} + {{(SLICE-1){1'b0}}, cin};
    top      = {1'b0, a[SLICE-1]} + {1'b0, b[SLICE-1]} + {1'b0, low[SLICE-1]};
    sum      = {top[0], low[SLICE-2:0]};
    cout     = top[1];
    c_msb_in = low[SLICE-1];
  end

endmodule

// File: rtl/wide_addsub_seq.sv
// W-bit add/subtract computed over W/SLICE cycles with one shared adder slice.
// Handshake: start_i is accepted on a rising edge while ready_o=1; done_o then pulses once and r_o/flags stay valid until the next accept.
module wide_addsub_seq
  import wide_addsub_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         sub_i,
  input  logic         flush_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [W-1:0] r_o,
  output logic         n_flag_o,
  output logic         z_flag_o,
  output logic         c_flag_o,
  output logic         v_flag_o,
  output state_e       state_o
);

  localparam int NUM_SLICE = W / SLICE;
  localparam int IDX_BITS  = idx_width(NUM_SLICE);
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_SLICE - 1);

  state_e                            state_q;
  logic [NUM_SLICE-1:0][SLICE-1:0]   a_q, bx_q, work_q, work_nxt, r_q;
  logic [IDX_BITS-1:0]               idx_q;
  logic                              carry_q, zacc_q, sub_q;
  logic                              n_q, z_q, c_q, v_q;
  logic [SLICE-1:0]                  sum;
  logic                              cout, c_msb_in;

  add_slice #(.SLICE(SLICE)) u_slice (
    .a       (a_q[idx_q]),
    .b       (bx_q[idx_q]),
    .cin     (carry_q),
    .sum     (sum),
    .cout    (cout),
    .c_msb_in(c_msb_in)
  );

  always_comb begin
    work_nxt        = work_q;
    work_nxt[idx_q] = sum;
  end

  // Slices build up in work_q; r_o is only published on the edge into DONE so a flush leaves it intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      zacc_q  <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= '0;
      bx_q    <= '0;
      work_q  <= '0;
      r_q     <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            a_q     <= a_i;
            bx_q    <= sub_i ? ~b_i : b_i;
            sub_q   <= sub_i;
            carry_q <= sub_i;
            idx_q   <= '0;
            zacc_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            idx_q   <= '0;
            state_q <= IDLE;
          end else begin
            work_q  <= work_nxt;
            carry_q <= cout;
            zacc_q  <= zacc_q & (sum == '0);
            if (idx_q == LAST_IDX) begin
              idx_q   <= '0;
              r_q     <= work_nxt;
              n_q     <= sum[SLICE-1];
              z_q     <= zacc_q & (sum == '0);
              c_q     <= cout ^ sub_q;
              v_q     <= cout ^ c_msb_in;
              state_q <= DONE;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = (state_q == RUN);
  assign done_o   = (state_q == DONE);
  assign r_o      = r_q;
  assign n_flag_o = n_q;
  assign z_flag_o = z_q;
  assign c_flag_o = c_q;
  assign v_flag_o = v_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_wide_addsub_seq.sv
// Self-checking bench for wide_addsub_seq: directed corner vectors, a start-held stream,
// reset and flush aborts, and randomized operations checked against a plain-arithmetic model.
module tb_wide_addsub_seq;
  import wide_addsub_pkg::*;

  localparam int W     = W_DEF;
  localparam int SLICE = SLICE_DEF;
  localparam int NS    = W / SLICE;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic         sub_i = 1'b0;
  logic         flush_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         ready_o, busy_o, done_o;
  logic [W-1:0] r_o;
  logic         n_flag_o, z_flag_o, c_flag_o, v_flag_o;
  state_e       state_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W-1:0] exp_q[$];
  logic [3:0]   exp_f_q[$];

  wide_addsub_seq #(.W(W), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .sub_i(sub_i), .flush_i(flush_i),
    .a_i(a_i), .b_i(b_i), .ready_o(ready_o), .busy_o(busy_o), .done_o(done_o),
    .r_o(r_o), .n_flag_o(n_flag_o), .z_flag_o(z_flag_o), .c_flag_o(c_flag_o),
    .v_flag_o(v_flag_o), .state_o(state_o)
  );

  // Clock and reset
  always #5 clk = ~clk;

  function automatic logic [3:0] flags();
    return {n_flag_o, z_flag_o, c_flag_o, v_flag_o};
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Reference model: whole-width arithmetic, ALU flags with borrow-style C for subtract.
  function automatic void ref_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic [3:0] nzcv);
    logic [W:0] full;
    logic       c, v;
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b};
      c    = full[W];
      v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} - {1'b0, b};
      c    = (a < b);
      v    = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
    end
    r    = full[W-1:0];
    nzcv = {r[W-1], (r == '0), c, v};
  endfunction

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom, $urandom, $urandom};
    endcase
  endfunction

  // Driver: one complete operation, with latency and handshake checks along the way.
  task automatic run_op(input string tag, input logic sub, input logic [W-1:0] a,
                        input logic [W-1:0] b, output logic [W-1:0] r, output logic [3:0] f);
    int lat;
    @(negedge clk);
    check({tag, " ready"}, W'(ready_o), W'(1'b1));
    start_i = 1'b1; sub_i = sub; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; sub_i = ~sub; a_i = ~a; b_i = ~b;
    check({tag, " busy"}, W'({busy_o, ready_o}), W'(2'b10));
    lat = 0;
    while (!done_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, W'(lat), W'(NS));
    r = r_o;
    f = flags();
    @(posedge clk); #1;
    check({tag, " done drop"}, W'({done_o, ready_o}), W'(2'b01));
  endtask

  task automatic model_op(input string tag, input logic sub, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    logic [W-1:0] r, er;
    logic [3:0]   f, ef;
    ref_op(sub, a, b, er, ef);
    run_op(tag, sub, a, b, r, f);
    check({tag, " r"}, r, er);
    check({tag, " nzcv"}, W'(f), W'(ef));
  endtask

  initial begin
    logic [W-1:0] r, r_keep;
    logic [3:0]   f, f_keep;
    logic [W-1:0] sa[12], sb[12];
    logic         ss[12];
    logic [W-1:0] er;
    logic [3:0]   ef;
    int           done_at[$];
    int           seen;

    repeat (3) @(posedge clk);
    #1;
    check("reset outs", W'({ready_o, busy_o, done_o, flags()}), W'(7'b1000000));
    check("reset r", r_o, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with hand-derived expectations {N,Z,C,V}
    run_op("add slice carry", 1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, r, f);
    check("add slice carry r", r, 128'h0000_0000_0000_0000_0000_0001_0000_0000);
    check("add slice carry nzcv", W'(f), W'(4'b0000));
    run_op("sub 0-1", 1'b1, '0, 128'h1, r, f);
    check("sub 0-1 r", r, '1);
    check("sub 0-1 nzcv", W'(f), W'(4'b1010));
    run_op("add ovf", 1'b0, {1'b0, {(W-1){1'b1}}}, 128'h1, r, f);
    check("add ovf r", r, {1'b1, {(W-1){1'b0}}});
    check("add ovf nzcv", W'(f), W'(4'b1001));
    run_op("add min+min", 1'b0, {1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, r, f);
    check("add min+min r", r, '0);
    check("add min+min nzcv", W'(f), W'(4'b0111));
    run_op("sub equal", 1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210,
           128'h0123456789ABCDEF_FEDCBA9876543210, r, f);
    check("sub equal r", r, '0);
    check("sub equal nzcv", W'(f), W'(4'b0100));

    // start_i held for 12 cycles: accepts expected at cycles 0 and 6 only
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < 12) begin
        ss[i] = 1'($urandom_range(0, 1)); sa[i] = rnd(); sb[i] = rnd();
        start_i = 1'b1; sub_i = ss[i]; a_i = sa[i]; b_i = sb[i];
        if (i == 0 || i == 6) begin
          ref_op(ss[i], sa[i], sb[i], er, ef);
          exp_q.push_back(er);
          exp_f_q.push_back(ef);
        end
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
      if (done_o) begin
        done_at.push_back(i);
        if (exp_q.size() > 0) begin
          check("stream r", r_o, exp_q.pop_front());
          check("stream nzcv", W'(flags()), W'(exp_f_q.pop_front()));
        end else begin
          check("stream extra done", W'(done_o), W'(1'b0));
        end
      end
    end
    check("stream pulses", W'(done_at.size()), W'(2));
    if (done_at.size() == 2) begin
      check("stream first done", W'(done_at[0]), W'(NS));
      check("stream spacing", W'(done_at[1] - done_at[0]), W'(NS + 2));
    end

    // Asynchronous reset during the second RUN cycle
    @(negedge clk);
    start_i = 1'b1; sub_i = 1'b0; a_i = rnd(); b_i = rnd();
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset outs", W'({ready_o, busy_o, done_o, flags()}), W'(7'b1000000));
    check("mid reset r", r_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_o) seen++;
    end
    check("mid reset no done", W'(seen), W'(0));

    // Flush in RUN: no done, previous result and flags retained
    model_op("pre flush", 1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1);
    ref_op(1'b0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, r_keep, f_keep);
    @(negedge clk);
    start_i = 1'b1; sub_i = 1'b1; a_i = rnd(); b_i = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush idle", W'({busy_o, ready_o}), W'(2'b01));
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done_o) seen++;
    end
    check("flush no done", W'(seen), W'(0));
    check("flush r kept", r_o, r_keep);
    check("flush nzcv kept", W'(flags()), W'(f_keep));
    model_op("post flush add", 1'b0, rnd(), rnd());

    // Randomized operations
    for (int i = 0; i < 20; i++) begin
      model_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), rnd(), rnd());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
